// File: rtl/seq_ser_pkg.sv
// Shared types and helpers for the parallel-to-serial front end.
package seq_ser_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    // Level driven on the serial line whenever no word is shifting.
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Bits needed for a counter that runs 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: valid/ready word intake, one bit per clock
// out, optional idle gap after each word, and a wrapping completed-word count.
module seq_serializer
    import seq_ser_pkg::*;
#(
    parameter int   WIDTH     = 8,
    parameter int   GAP       = 0,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT,
    parameter bit   MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid,
    output logic             ready,
    output logic             Out,
    output logic             busy,
    output logic             last_bit,
    output logic [15:0]      words_sent
);

    localparam int BW = cnt_width(WIDTH);
    localparam int GW = cnt_width(GAP);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [GW-1:0]    gap_cnt;
    logic [15:0]      sent_cnt;
    logic             accept;
    logic             shift_done;
    logic             gap_done;

    assign words_sent = sent_cnt;

    // Next-state and output decode; outputs depend only on registered state,
    // so valid only steers the next state, never ready or Out.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case statements can leave a latch behind.
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        last_bit   = 1'b0;
        Out        = IDLE_BIT;
        shift_done = (state == S_SHIFT) && (bit_cnt == BIT_LAST);
        gap_done   = (GAP > 0) && (state == S_GAP) && (gap_cnt == GAP_LAST);

        case (state)
            S_IDLE: ready = 1'b1;
            S_SHIFT: begin
                busy     = 1'b1;
                Out      = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                last_bit = shift_done;
                ready    = shift_done && (GAP == 0);
            end
            S_GAP: begin
                busy  = 1'b1;
                ready = gap_done;
            end
            default: ;
        endcase

        accept = valid && ready;

        case (state)
            S_IDLE:  if (accept) state_next = S_SHIFT;
            S_SHIFT: begin
                if (shift_done) begin
                    if (GAP > 0)     state_next = S_GAP;
                    else if (accept) state_next = S_SHIFT;
                    else             state_next = S_IDLE;
                end
            end
            S_GAP:   if (gap_done) state_next = accept ? S_SHIFT : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of block ordering.
        if (!rst) state <= S_IDLE;
        else      state <= state_next;
    end

    // Shift register, bit/gap counters and completed-word count.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the shift register is cleared on reset too, so a word cut off
        // mid-shift leaves nothing behind for the next one.
        if (!rst) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
            sent_cnt <= '0;
        end else begin
            if (accept) begin
                shreg   <= data_in;
                bit_cnt <= '0;
            end else if ((state == S_SHIFT) && !shift_done) begin
                shreg   <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (shift_done) sent_cnt <= sent_cnt + 1'b1;

            if (shift_done)                     gap_cnt <= '0;
            else if ((state == S_GAP) && !gap_done) gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule
